// File: rtl/seq_mult_param_if.sv
// seq_mult_param_if: operand/result valid-ready handshake bundle for seq_mult_param.
interface seq_mult_param_if #(parameter int WIDTH = 32);
   logic                 in_valid, in_ready, is_signed;
   logic [WIDTH-1:0]     a, b;
   logic                 out_valid, out_ready, ovf, busy;
   logic [2*WIDTH-1:0]   res;
   modport master (
      output in_valid, a, b, is_signed, out_ready,
      input  in_ready, out_valid, res, ovf, busy
   );
   modport slave (
      input  in_valid, a, b, is_signed, out_ready,
      output in_ready, out_valid, res, ovf, busy
   );
endinterface

// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add sequential multiplier, signed/unsigned per op, valid/ready in and out.
// Define SEQ_MULT_EARLY_TERM_EN to leave RUN once the remaining multiplier bits are all zero.
module seq_mult_param #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic           clk,
   input  logic           reset,
   seq_mult_param_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t               r_state, w_state_nxt;
   logic                 r_signed, r_neg;
   logic [2*WIDTH-1:0]   r_mcand, r_acc, w_res;
   logic [WIDTH-1:0]     r_mplr, w_mplr_nxt, w_mag_a, w_mag_b;
   logic [CNT_W-1:0]     r_cnt;
   logic                 w_accept, w_last, w_hi_zero, w_hi_ones;

   assign w_accept   = bus.in_valid && r_state == S_IDLE;
   // Magnitudes are W bits with no sign bit, so |-2^(W-1)| = 2^(W-1) still fits.
   assign w_mag_a    = (bus.is_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
   assign w_mag_b    = (bus.is_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   assign w_mplr_nxt = r_mplr >> 1;
`ifdef SEQ_MULT_EARLY_TERM_EN
   assign w_last     = r_cnt == CNT_W'(WIDTH - 1) || w_mplr_nxt == '0;
`else
   assign w_last     = r_cnt == CNT_W'(WIDTH - 1);
`endif
   assign w_res      = r_neg ? -r_acc : r_acc;
   assign w_hi_zero  = ~|w_res[2*WIDTH-1:WIDTH-1];
   assign w_hi_ones  = &w_res[2*WIDTH-1:WIDTH-1];

   always_ff @(posedge clk) begin
      if (reset)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.in_valid) w_state_nxt = S_RUN;
         S_RUN:   if (w_last) w_state_nxt = S_DONE;
         S_DONE:  if (bus.out_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = r_state == S_IDLE;
      bus.busy      = r_state == S_RUN;
      bus.out_valid = r_state == S_DONE;
      bus.res       = w_res;
      bus.ovf       = r_signed ? !(w_hi_zero || w_hi_ones) : |w_res[2*WIDTH-1:WIDTH];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_signed <= 1'b0;
         r_neg    <= 1'b0;
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (w_accept) begin
         r_signed <= bus.is_signed;
         r_neg    <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         r_mcand  <= {{WIDTH{1'b0}}, w_mag_a};
         r_mplr   <= w_mag_b;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
         if (r_mplr[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplr   <= w_mplr_nxt;
         r_cnt    <= r_cnt + 1'b1;
      end
   end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: directed vectors on a 32-bit and an 8-bit multiplier, checked against a
// behavioural product/latency model plus literal expectations.
module tb_seq_mult_param;
   logic clk = 1'b0, reset = 1'b1;
   int   n_cmp = 0, n_fail = 0;
   always #5 clk = ~clk;

   seq_mult_param_if #(.WIDTH(32)) bus ();
   seq_mult_param_if #(.WIDTH(8))  bus8 ();
   seq_mult_param #(.WIDTH(32)) dut  (.clk(clk), .reset(reset), .bus(bus));
   seq_mult_param #(.WIDTH(8))  dut8 (.clk(clk), .reset(reset), .bus(bus8));

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int bitlen(input logic [31:0] x);
      int n = 1;
      for (int i = 0; i < 32; i++) if (x[i]) n = i + 1;
      return n;
   endfunction

   // Model of the 32-bit unit: phase 0 idle, 1 computing, 2 holding a result.
   localparam longint LIM = 64'sd2147483648;
   int          m_state = 0, m_left = 0;
   logic [63:0] m_res = '0;
   logic        m_ovf = 1'b0;
   bit          m_on = 0, m_rst = 0;
   always @(posedge clk) begin
      longint      p;
      logic [63:0] pu;
      logic [31:0] mb;
      m_rst = reset;
      if (reset) begin
         m_on = 1; m_state = 0; m_res = '0; m_ovf = 1'b0;
      end else if (m_state == 0 && bus.in_valid) begin
         if (bus.is_signed) begin
            p     = longint'($signed(bus.a)) * longint'($signed(bus.b));
            m_res = p;
            m_ovf = p < -LIM || p >= LIM;
            mb    = bus.b[31] ? -bus.b : bus.b;
         end else begin
            pu    = {32'b0, bus.a} * {32'b0, bus.b};
            m_res = pu;
            m_ovf = pu[63:32] != 0;
            mb    = bus.b;
         end
`ifdef SEQ_MULT_EARLY_TERM_EN
         m_left = bitlen(mb);
`else
         m_left = 32;
`endif
         m_state = 1;
      end else if (m_state == 1) begin
         m_left--;
         if (m_left == 0) m_state = 2;
      end else if (m_state == 2 && bus.out_ready) m_state = 0;
   end

   always @(negedge clk) begin
      if (m_on) begin
         check("in_ready", bus.in_ready, m_state == 0);
         check("busy", bus.busy, m_state == 1);
         check("out_valid", bus.out_valid, m_state == 2);
         if (m_state == 2 || m_rst) begin
            check("res", bus.res, m_res);
            check("ovf", bus.ovf, m_ovf);
         end
      end
   end

   task automatic start(input logic [31:0] a, input logic [31:0] b, input logic s);
      @(posedge clk); #1;
      bus.a = a; bus.b = b; bus.is_signed = s; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0; bus.a = 32'h1234_5678; bus.b = 32'h0F0F_0F0F; bus.is_signed = ~s;
   endtask

   task automatic op(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input logic [63:0] er, input logic eo, input int el, input bit hold);
      int lat = 0, want;
`ifdef SEQ_MULT_EARLY_TERM_EN
      want = el;
`else
      want = 32;
`endif
      start(a, b, s);
      lat = 0;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("latency", lat, want);
      check("res_lit", bus.res, er);
      check("ovf_lit", bus.ovf, eo);
      if (!hold) begin
         bus.out_ready = 1'b1;
         @(posedge clk); #1;
         bus.out_ready = 1'b0;
         check("in_ready_after", bus.in_ready, 1);
      end
   endtask

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                      input logic [15:0] er, input logic eo, input int el);
      int lat = 0, want;
`ifdef SEQ_MULT_EARLY_TERM_EN
      want = el;
`else
      want = 8;
`endif
      @(posedge clk); #1;
      bus8.a = a; bus8.b = b; bus8.is_signed = s; bus8.in_valid = 1'b1;
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      while (!bus8.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      check("w8_latency", lat, want);
      check("w8_res", bus8.res, er);
      check("w8_ovf", bus8.ovf, eo);
      bus8.out_ready = 1'b1;
      @(posedge clk); #1;
      bus8.out_ready = 1'b0;
      check("w8_in_ready", bus8.in_ready, 1);
   endtask

   initial begin
      bus.in_valid = 0; bus.a = 0; bus.b = 0; bus.is_signed = 0; bus.out_ready = 0;
      bus8.in_valid = 0; bus8.a = 0; bus8.b = 0; bus8.is_signed = 0; bus8.out_ready = 0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      check("rst_res", bus.res, 0);
      check("rst_in_ready", bus.in_ready, 1);
      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 64'hFFFF_FFFE_0000_0001, 1, 32, 0);
      op(32'hFFFF_FFF9, 32'd6,         1, 64'hFFFF_FFFF_FFFF_FFD6, 0, 3,  0);
      op(32'h8000_0000, 32'h8000_0000, 1, 64'h4000_0000_0000_0000, 1, 32, 0);
      op(32'd100,       32'd5,         0, 64'd500,                 0, 3,  0);
      op(32'd5,         32'h8000_0000, 0, 64'h2_8000_0000,         1, 32, 0);
      op(32'hFFFF_FFFF, 32'd0,         1, 64'd0,                   0, 1,  0);
      op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFF_8000_0001, 0, 1,  0);
      op(32'h8000_0000, 32'd1,         1, 64'hFFFF_FFFF_8000_0000, 0, 1,  0);
      op(32'h8000_0000, 32'hFFFF_FFFF, 1, 64'h0000_0000_8000_0000, 1, 1,  0);
      op(32'h0001_0000, 32'h0000_8000, 0, 64'h8000_0000,           0, 16, 0);
      op(32'h0001_0000, 32'h0000_8000, 1, 64'h8000_0000,           1, 16, 0);
      // Backpressure: result held for 10 cycles while stray operands are offered.
      op(32'hFFFF_FFF9, 32'd6, 1, 64'hFFFF_FFFF_FFFF_FFD6, 0, 3, 1);
      for (int i = 0; i < 10; i++) begin
         bus.in_valid = i[0]; bus.a = 32'(i + 9); bus.b = 32'd3; bus.is_signed = 0;
         @(posedge clk); #1;
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_in_ready", bus.in_ready, 0);
         check("bp_res", bus.res, 64'hFFFF_FFFF_FFFF_FFD6);
         check("bp_ovf", bus.ovf, 0);
      end
      bus.in_valid = 0; bus.out_ready = 1;
      @(posedge clk); #1;
      bus.out_ready = 0;
      check("bp_release", bus.in_ready, 1);
      // Reset mid-RUN, then a clean operation.
      start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("abort_in_ready", bus.in_ready, 1);
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_busy", bus.busy, 0);
      check("abort_res", bus.res, 0);
      op(32'd3, 32'd4, 0, 64'd12, 0, 3, 0);
      // Reset while a result waits in DONE.
      op(32'd7, 32'd9, 0, 64'd63, 0, 4, 1);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("done_rst_out_valid", bus.out_valid, 0);
      check("done_rst_res", bus.res, 0);
      op8(8'hFF, 8'h00, 1, 16'h0000, 0, 1);
      op8(8'hFF, 8'h00, 0, 16'h0000, 0, 1);
      op8(8'h80, 8'h80, 1, 16'h4000, 1, 8);
      op8(8'hFF, 8'hFF, 0, 16'hFE01, 1, 8);
      op8(8'hFD, 8'h05, 1, 16'hFFF1, 0, 3);
      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end
endmodule
